// File: rtl/param_router.sv
`default_nettype none
// ============================================================================
//  Module      : param_router
//  Description : Store-and-forward router buffer. Words from dp_bus are held in
//                addressed slots, each with a valid bit. A forward moves a slot
//                onto the registered r_out port and frees the slot. A flush
//                state machine drains every valid slot in ascending order.
//                Optional feature macro: ROUTER_BYPASS_EN (same-address
//                store+forward to an empty slot passes dp_bus straight out).
//  Revision    : 1.0 - initial release
// ============================================================================
module param_router #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] dp_bus,
  input  logic [AW-1:0]     inAddr,
  input  logic [AW-1:0]     outAddr,
  input  logic              st_router,
  input  logic              fw_router,
  input  logic              flush,
  output logic [DATA_W-1:0] r_out,
  output logic              r_valid,
  output logic [AW-1:0]     r_addr,
  output logic              received,
  output logic              acknowledge,
  output logic              err_ovr,
  output logic              err_empty,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty,
  output logic              flush_done
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       ptr_q, ptr_d;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [AW:0]         count_q, count_d;
  logic [DATA_W-1:0]   r_out_q, r_out_d;
  logic [AW-1:0]       r_addr_q, r_addr_d;
  logic                r_valid_q, r_valid_d;
  logic                received_q, received_d;
  logic                err_ovr_q, err_ovr_d;
  logic                err_empty_q, err_empty_d;
  logic                flush_done_q, flush_done_d;

  logic [DATA_W-1:0]   buf_q [DEPTH];
  logic                wr_en;
  logic                inc;
  logic                dec;
  logic                same_addr;

  assign same_addr = st_router && fw_router && (inAddr == outAddr);

  // Next-state logic for the FSM, slot valid bits, occupancy and output strobes.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    valid_d      = valid_q;
    r_out_d      = r_out_q;
    r_addr_d     = r_addr_q;
    r_valid_d    = 1'b0;
    received_d   = 1'b0;
    err_ovr_d    = 1'b0;
    err_empty_d  = 1'b0;
    flush_done_d = 1'b0;
    wr_en        = 1'b0;
    inc          = 1'b0;
    dec          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          // Flush wins over any store/forward in the same cycle.
          if (count_q != '0) begin
            state_d = ST_FLUSH;
            ptr_d   = '0;
          end
        end else if (same_addr && valid_q[inAddr]) begin
          // Swap: old word leaves, new word takes its place; slot stays valid.
          r_out_d    = buf_q[outAddr];
          r_addr_d   = outAddr;
          r_valid_d  = 1'b1;
          wr_en      = 1'b1;
          received_d = 1'b1;
        end else if (same_addr) begin
`ifdef ROUTER_BYPASS_EN
          // Empty slot: the incoming word goes straight out, never stored.
          r_out_d    = dp_bus;
          r_addr_d   = outAddr;
          r_valid_d  = 1'b1;
          received_d = 1'b1;
`else
          // Empty slot: the store lands, the forward reports an empty slot.
          wr_en           = 1'b1;
          valid_d[inAddr] = 1'b1;
          inc             = 1'b1;
          received_d      = 1'b1;
          err_empty_d     = 1'b1;
`endif
        end else begin
          if (st_router) begin
            if (!valid_q[inAddr]) begin
              wr_en           = 1'b1;
              valid_d[inAddr] = 1'b1;
              inc             = 1'b1;
              received_d      = 1'b1;
            end else begin
              err_ovr_d = 1'b1;
            end
          end
          if (fw_router) begin
            if (valid_q[outAddr]) begin
              r_out_d          = buf_q[outAddr];
              r_addr_d         = outAddr;
              r_valid_d        = 1'b1;
              valid_d[outAddr] = 1'b0;
              dec              = 1'b1;
            end else begin
              err_empty_d = 1'b1;
            end
          end
        end
      end

      ST_FLUSH: begin
        if (valid_q[ptr_q]) begin
          r_out_d        = buf_q[ptr_q];
          r_addr_d       = ptr_q;
          r_valid_d      = 1'b1;
          valid_d[ptr_q] = 1'b0;
          dec            = 1'b1;
        end
        if (ptr_q == AW'(DEPTH - 1)) begin
          flush_done_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    count_d = count_q + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
  end

  // Control state, occupancy and registered outputs with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      valid_q      <= '0;
      count_q      <= '0;
      r_out_q      <= '0;
      r_addr_q     <= '0;
      r_valid_q    <= 1'b0;
      received_q   <= 1'b0;
      err_ovr_q    <= 1'b0;
      err_empty_q  <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      valid_q      <= valid_d;
      count_q      <= count_d;
      r_out_q      <= r_out_d;
      r_addr_q     <= r_addr_d;
      r_valid_q    <= r_valid_d;
      received_q   <= received_d;
      err_ovr_q    <= err_ovr_d;
      err_empty_q  <= err_empty_d;
      flush_done_q <= flush_done_d;
    end
  end

  // Slot storage; contents are meaningless until the valid bit is set, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_q[inAddr] <= dp_bus;
    end
  end

  assign r_out       = r_out_q;
  assign r_addr      = r_addr_q;
  assign r_valid     = r_valid_q;
  assign received    = received_q;
  assign err_ovr     = err_ovr_q;
  assign err_empty   = err_empty_q;
  assign flush_done  = flush_done_q;
  assign count       = count_q;
  assign full        = (count_q == (AW + 1)'(DEPTH));
  assign empty       = (count_q == '0);
  assign acknowledge = (state_q == ST_IDLE) && !st_router && !fw_router;

endmodule
`default_nettype wire

// File: tb/tb_param_router.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_router
//  Description : Self-checking bench for param_router (DATA_W=8, DEPTH=16).
//                Directed scenarios plus randomized traffic, compared each
//                cycle against a slot-level behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_param_router;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] dp_bus;
  logic [AW-1:0]     inAddr;
  logic [AW-1:0]     outAddr;
  logic              st_router;
  logic              fw_router;
  logic              flush;
  logic [DATA_W-1:0] r_out;
  logic              r_valid;
  logic [AW-1:0]     r_addr;
  logic              received;
  logic              acknowledge;
  logic              err_ovr;
  logic              err_empty;
  logic [AW:0]       count;
  logic              full;
  logic              empty;
  logic              flush_done;

  param_router #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .dp_bus     (dp_bus),
    .inAddr     (inAddr),
    .outAddr    (outAddr),
    .st_router  (st_router),
    .fw_router  (fw_router),
    .flush      (flush),
    .r_out      (r_out),
    .r_valid    (r_valid),
    .r_addr     (r_addr),
    .received   (received),
    .acknowledge(acknowledge),
    .err_ovr    (err_ovr),
    .err_empty  (err_empty),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .flush_done (flush_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: slot contents and valid flags, plus the expected outputs.
  bit          m_valid [DEPTH];
  logic [7:0]  m_buf   [DEPTH];
  bit          m_flushing;
  int          m_ptr;
  logic [7:0]  e_r_out;
  int          e_r_addr;
  bit          e_r_valid, e_received, e_err_ovr, e_err_empty, e_flush_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += m_valid[i] ? 1 : 0;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    m_flushing = 1'b0;
    m_ptr = 0;
    e_r_out = 8'h00; e_r_addr = 0;
    e_r_valid = 0; e_received = 0; e_err_ovr = 0; e_err_empty = 0; e_flush_done = 0;
  endtask

  // One clock of behaviour, evaluated on the inputs present before the edge.
  task automatic model_step(input bit st, input bit fw, input bit fl,
                            input logic [7:0] d, input int ia, input int oa);
    bit         vin, vout;
    logic [7:0] old_word;
    e_r_valid = 0; e_received = 0; e_err_ovr = 0; e_err_empty = 0; e_flush_done = 0;
    if (m_flushing) begin
      if (m_valid[m_ptr]) begin
        e_r_out = m_buf[m_ptr]; e_r_addr = m_ptr; e_r_valid = 1; m_valid[m_ptr] = 0;
      end
      if (m_ptr == DEPTH - 1) begin
        e_flush_done = 1; m_flushing = 0;
      end else begin
        m_ptr++;
      end
    end else if (fl) begin
      if (m_count() > 0) begin
        m_flushing = 1; m_ptr = 0;
      end
    end else begin
      vin = m_valid[ia]; vout = m_valid[oa]; old_word = m_buf[oa];
      if (st && fw && ia == oa && !vin) begin
`ifdef ROUTER_BYPASS_EN
        e_r_out = d; e_r_addr = oa; e_r_valid = 1; e_received = 1;
`else
        m_buf[ia] = d; m_valid[ia] = 1; e_received = 1; e_err_empty = 1;
`endif
      end else begin
        if (fw) begin
          if (vout) begin
            e_r_out = old_word; e_r_addr = oa; e_r_valid = 1; m_valid[oa] = 0;
          end else begin
            e_err_empty = 1;
          end
        end
        if (st) begin
          if (!vin || (fw && ia == oa)) begin
            m_buf[ia] = d; m_valid[ia] = 1; e_received = 1;
          end else begin
            e_err_ovr = 1;
          end
        end
      end
    end
  endtask

  task automatic check_outputs(input string where);
    int n;
    n = m_count();
    check({where, ":r_out"},      32'(r_out),      32'(e_r_out));
    check({where, ":r_addr"},     32'(r_addr),     32'(e_r_addr));
    check({where, ":r_valid"},    32'(r_valid),    32'(e_r_valid));
    check({where, ":received"},   32'(received),   32'(e_received));
    check({where, ":err_ovr"},    32'(err_ovr),    32'(e_err_ovr));
    check({where, ":err_empty"},  32'(err_empty),  32'(e_err_empty));
    check({where, ":flush_done"}, 32'(flush_done), 32'(e_flush_done));
    check({where, ":count"},      32'(count),      32'(n));
    check({where, ":full"},       32'(full),       32'(n == DEPTH));
    check({where, ":empty"},      32'(empty),      32'(n == 0));
  endtask

  // Called at posedge+1; drives inputs, checks acknowledge, clocks, checks outputs.
  task automatic cycle(input string where, input bit st, input bit fw, input bit fl,
                       input logic [7:0] d, input int ia, input int oa);
    st_router = st; fw_router = fw; flush = fl;
    dp_bus = d; inAddr = AW'(ia); outAddr = AW'(oa);
    #1;
    check({where, ":ack"}, 32'(acknowledge), 32'(!m_flushing && !st && !fw));
    model_step(st, fw, fl, d, ia, oa);
    @(posedge clk);
    #1;
    check_outputs(where);
  endtask

  task automatic idle(input string where);
    cycle(where, 0, 0, 0, 8'h00, 0, 0);
  endtask

  task automatic async_reset(input string where);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs(where);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; st_router = 0; fw_router = 0; flush = 0;
    dp_bus = '0; inAddr = '0; outAddr = '0;
    model_reset();

    // 1. Reset pulse between clock edges.
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    check_outputs("reset");
    check("reset:ack", 32'(acknowledge), 32'd1);
    @(posedge clk);
    #1;

    // 2. Store then forward.
    cycle("t2_store", 1, 0, 0, 8'hA5, 3, 0);
    check("t2:received", 32'(received), 32'd1);
    check("t2:count1",   32'(count),    32'd1);
    cycle("t2_fwd", 0, 1, 0, 8'h00, 0, 3);
    check("t2:r_out",  32'(r_out),  32'hA5);
    check("t2:r_addr", 32'(r_addr), 32'd3);
    check("t2:count0", 32'(count),  32'd0);

    // 3. Overwrite rejection, then forwarding an emptied slot.
    cycle("t3_s1", 1, 0, 0, 8'h11, 5, 0);
    cycle("t3_s2", 1, 0, 0, 8'h22, 5, 0);
    check("t3:err_ovr", 32'(err_ovr), 32'd1);
    cycle("t3_f1", 0, 1, 0, 8'h00, 0, 5);
    check("t3:r_out", 32'(r_out), 32'h11);
    cycle("t3_f2", 0, 1, 0, 8'h00, 0, 5);
    check("t3:err_empty", 32'(err_empty), 32'd1);

    // 4. Same-address store+forward on a valid slot.
    cycle("t4_s", 1, 0, 0, 8'h33, 7, 0);
    cycle("t4_sf", 1, 1, 0, 8'h44, 7, 7);
    check("t4:r_out_old", 32'(r_out), 32'h33);
    check("t4:count",     32'(count), 32'd1);
    cycle("t4_f", 0, 1, 0, 8'h00, 0, 7);
    check("t4:r_out_new", 32'(r_out), 32'h44);

    // 5. Flush timing: r_valid on cycles 3, 10, 16 after entry.
    cycle("t5_a", 1, 0, 0, 8'h02, 2, 0);
    cycle("t5_b", 1, 0, 0, 8'h09, 9, 0);
    cycle("t5_c", 1, 0, 0, 8'h0F, 15, 0);
    cycle("t5_enter", 1, 1, 1, 8'hEE, 4, 2);
    for (int k = 1; k <= DEPTH; k++) begin
      cycle("t5_flush", 1, 1, 1, 8'hEE, 4, 2);
      check("t5:rv_slot", 32'(r_valid), 32'(k == 3 || k == 10 || k == 16));
    end
    check("t5:done", 32'(flush_done), 32'd1);
    check("t5:count", 32'(count), 32'd0);

    // Second flush interrupted by reset at cycle 5.
    cycle("t5_r1", 1, 0, 0, 8'h61, 1, 0);
    cycle("t5_r2", 1, 0, 0, 8'h6C, 12, 0);
    cycle("t5_renter", 0, 0, 1, 8'h00, 0, 0);
    for (int k = 1; k <= 5; k++) idle("t5_rflush");
    async_reset("t5_rst");
    for (int k = 0; k < 14; k++) begin
      idle("t5_after");
      check("t5:no_rv", 32'(r_valid), 32'd0);
    end

    // 6. Same-address store+forward on an empty slot.
    cycle("t6", 1, 1, 0, 8'h5A, 4, 4);
`ifdef ROUTER_BYPASS_EN
    check("t6:r_out",   32'(r_out),   32'h5A);
    check("t6:r_valid", 32'(r_valid), 32'd1);
    check("t6:count",   32'(count),   32'd0);
`else
    check("t6:err_empty", 32'(err_empty), 32'd1);
    check("t6:count",     32'(count),     32'd1);
`endif

    // Randomized traffic against the model; narrow address range forces collisions.
    for (int n = 0; n < 600; n++) begin
      int ia, oa;
      bit st, fw, fl;
      ia = (n < 300) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, DEPTH - 1));
      oa = ($urandom_range(0, 3) == 0) ? ia : int'($urandom_range(0, DEPTH - 1));
      st = ($urandom_range(0, 99) < 60);
      fw = ($urandom_range(0, 99) < 40);
      fl = ($urandom_range(0, 39) == 0);
      cycle("rand", st, fw, fl, 8'($urandom), ia, oa);
    end

    // Fill every slot to reach the full boundary.
    for (int a = 0; a < DEPTH; a++) begin
      if (m_flushing) idle("fill_wait");
      else if (!m_valid[a]) cycle("fill", 1, 0, 0, 8'($urandom), a, 0);
    end
    while (m_flushing) idle("fill_wait2");
    for (int a = 0; a < DEPTH; a++)
      if (!m_valid[a]) cycle("fill2", 1, 0, 0, 8'($urandom), a, 0);
    check("full:flag", 32'(full), 32'd1);
    cycle("full_flush", 0, 0, 1, 8'h00, 0, 0);
    for (int k = 0; k < DEPTH; k++) cycle("full_drain", 1, 0, 0, 8'h77, k, 0);
    check("full:empty", 32'(empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
